simd_alu_pipe: RTL and testbench
================================

# simd_alu_pipe

Parametrised, lane-sliced successor to the SPU scalar ALU. It executes integer add, subtract, multiply, AND, OR, shift and rotate independently on LANES lanes of LANE_WIDTH bits. It adds a valid/ready issue handshake, a registered result with a valid strobe, per-lane zero flags and an illegal-opcode error. It sits between the SPU register-file read stage and the writeback stage.

## Interface
- LANE_WIDTH, 32, bits per lane; power of two, ≥8
- LANES, 4, lane count; data width W = LANE_WIDTH*LANES
- clk_fake  in  1  clock; all flops update on its falling edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept; high exactly when FSM is IDLE
- opCode  in  4  operation select, sampled on accept
- inA  in  W  operand A, sampled on accept
- inB  in  W  operand B, sampled on accept
- out_valid  out  1  one-cycle strobe: dataOut/zeroOut/err are new
- dataOut  out  W  result, registered
- zeroOut  out  LANES  bit i = 1 when result lane i == 0
- err  out  1  result came from an illegal opcode

## Operation
- Accept = in_valid && in_ready at a falling edge. The operands and opCode are captured at that edge.
- Opcodes, per lane, unsigned, wrap modulo 2^LANE_WIDTH:
  - 0000 add, A+B
  - 0001 sub, A−B
  - 0010 mul, low LANE_WIDTH bits of A*B
  - 0011 AND
  - 0100 OR
  - 0111 shift left logical of A by B[log2(LANE_WIDTH)-1:0] of the same lane
  - 1000 rotate left of A by the same amount
- Illegal opcodes: 0101, 0110 (float slots, reserved) and 1001–1111.
  - dataOut = 0, zeroOut = 0, err = 1.
  - Single-cycle timing; the opcode is still accepted.
- Class S (single-cycle): 0000, 0001, 0011, 0100 and the illegal opcodes.
- Class M (two-cycle): 0010, 0111, 1000.
- FSM states:
  - IDLE:
    - Accept of class S: result registered at the same edge, stay IDLE.
    - Accept of class M: stage-1 register loaded, go to EXEC.
    - No accept: out_valid = 0.
  - EXEC:
    - in_ready = 0.
    - Next edge: result registered, out_valid = 1, return to IDLE.
    - in_valid is ignored in EXEC.
- Stage-1 contents:
  - mul: lane-wise products.
  - shift/rotate: operand and amount, pre-masked.
- When out_valid = 0, dataOut, zeroOut and err hold their last values. Outputs are never driven to z.
- There is no output backpressure. The consumer must take the result in the out_valid cycle.

## Timing
- Reset (async assert) values:
  - dataOut = 0, zeroOut = 0, err = 0, out_valid = 0.
  - FSM = IDLE, so in_ready = 1 once rst_n is high.
- Latency:
  - Class S accepted at edge N → out_valid high from edge N to edge N+1.
  - Class M accepted at edge N → out_valid high from edge N+1 to edge N+2.
- Throughput:
  - Class S: one per cycle.
  - Class M: one per two cycles.
  - A new op can be accepted at the edge where the EXEC result registers? No: in_ready is low in EXEC. The next accept is at edge N+2 at the earliest.
- Back-to-back class S ops give a continuous out_valid with a new result every cycle.
- in_ready is combinational from FSM state only. It never depends on in_valid.
- Reset mid-EXEC: the operation is discarded, no out_valid is produced, and the FSM returns to IDLE.
- Shift/rotate amount 0 → result = A.

## Configuration
- SPU_ALU_SAT_EN defined:
  - 0000 and 0001 become signed saturating per lane, clamping to [−2^(LANE_WIDTH−1), 2^(LANE_WIDTH−1)−1].
  - zeroOut is computed on the clamped value.
- SPU_ALU_SAT_EN undefined: add and sub wrap modulo 2^LANE_WIDTH.
- All other opcodes are unaffected.

## Test plan
Parameters: LANE_WIDTH = 32, LANES = 4.
1. Reset: assert rst_n = 0 mid-cycle → all outputs 0 immediately and in_ready = 1 after release. Then add A = {1,2,3,4}, B = {4,3,2,0xFFFFFFFF} → dataOut = {5,5,5,3}, zeroOut = 0000, out_valid one cycle after accept edge.
2. Sub with A = B = any value → dataOut = 0, zeroOut = 1111. Then A lane0 = 0, B lane0 = 1 → lane0 = 0xFFFFFFFF when the macro is off; with SPU_ALU_SAT_EN defined, lane0 = 0xFFFFFFFF (−1, in range).
3. Mul with lane0 0x10000 × 0x10000 and lane1 7 × 6 → lane0 = 0, lane1 = 42, zeroOut[0] = 1. in_ready low for exactly one cycle; out_valid at N+1. A second op with in_valid held high is accepted at N+2.
4. Rotate A lane0 = 0x80000001 by B lane0 = 33 (amount 1) → 0x00000003. Shift of the same operands → 0x00000002.
5. Opcode 0101 → err = 1, dataOut = 0, zeroOut = 0000, single-cycle. A following legal AND clears err.
6. Mul accepted, then rst_n pulsed low before the EXEC edge → no out_valid, FSM back to IDLE. A saturating add of 0x7FFFFFFF + 1 with the macro defined → 0x7FFFFFFF.

Source files
------------

// File: rtl/simd_alu_pipe.sv
// Lane-sliced SIMD integer ALU; SPU_ALU_SAT_EN selects signed saturating add/sub.
// Latency: add/sub/logic/illegal register at the accept edge; mul/shl/rol one edge later.
// Backpressure: in_ready drops for the EXEC cycle only; results are never held for the consumer.
module simd_alu_pipe #(
    parameter int LANE_WIDTH = 32,
    parameter int LANES      = 4
) (
    input  logic                        clk_fake,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  opCode,
    input  logic [LANE_WIDTH*LANES-1:0] inA,
    input  logic [LANE_WIDTH*LANES-1:0] inB,
    output logic                        out_valid,
    output logic [LANE_WIDTH*LANES-1:0] dataOut,
    output logic [LANES-1:0]            zeroOut,
    output logic                        err
);

    localparam int W   = LANE_WIDTH * LANES;
    localparam int SHW = $clog2(LANE_WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0111;
    localparam logic [3:0] OP_ROL = 4'b1000;

    typedef enum logic {IDLE, EXEC} state_t;
    typedef enum logic [1:0] {M_MUL, M_SHL, M_ROL} mop_t;

    state_t                 state_q, state_d;
    mop_t                   s1_op_q, s1_op_d;
    logic [W-1:0]           s1_dat_q, s1_dat_d;
    logic [LANES*SHW-1:0]   s1_amt_q, s1_amt_d;
    logic [W-1:0]           dout_q, dout_d;
    logic [LANES-1:0]       zero_q, zero_d;
    logic                   err_q, err_d;
    logic                   vld_q, vld_d;

    logic [W-1:0]           s_res, prod, m_res;
    logic [LANES*SHW-1:0]   amt_in;
    logic [LANES-1:0]       s_zero, m_zero;
    logic                   accept, is_m, illegal;
    mop_t                   mop_in;

    function automatic logic [LANE_WIDTH-1:0] addsub_lane(
        input logic [LANE_WIDTH-1:0] a,
        input logic [LANE_WIDTH-1:0] b,
        input logic                  sub
    );
        logic [LANE_WIDTH-1:0] r;
`ifdef SPU_ALU_SAT_EN
        logic [LANE_WIDTH:0] ext;
        if (sub) ext = {a[LANE_WIDTH-1], a} - {b[LANE_WIDTH-1], b};
        else     ext = {a[LANE_WIDTH-1], a} + {b[LANE_WIDTH-1], b};
        // Top two bits disagree only when the signed result left the lane range.
        if (ext[LANE_WIDTH] != ext[LANE_WIDTH-1])
            r = ext[LANE_WIDTH] ? {1'b1, {(LANE_WIDTH-1){1'b0}}} : {1'b0, {(LANE_WIDTH-1){1'b1}}};
        else
            r = ext[LANE_WIDTH-1:0];
`else
        r = sub ? (a - b) : (a + b);
`endif
        return r;
    endfunction

    function automatic logic [LANE_WIDTH-1:0] lane_s(
        input logic [3:0]            op,
        input logic [LANE_WIDTH-1:0] a,
        input logic [LANE_WIDTH-1:0] b
    );
        logic [LANE_WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_ADD:  r = addsub_lane(a, b, 1'b0);
            OP_SUB:  r = addsub_lane(a, b, 1'b1);
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [LANE_WIDTH-1:0] lane_m(
        input mop_t                  op,
        input logic [LANE_WIDTH-1:0] d,
        input logic [SHW-1:0]        amt
    );
        logic [LANE_WIDTH-1:0] r;
        r = d;
        case (op)
            M_MUL:   r = d;
            M_SHL:   r = d << amt;
            // A zero amount shifts the right half out by the full width, leaving d.
            M_ROL:   r = (d << amt) | (d >> (LANE_WIDTH - int'(amt)));
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        s_res  = '0;
        prod   = '0;
        m_res  = '0;
        amt_in = '0;
        s_zero = '0;
        m_zero = '0;
        for (int i = 0; i < LANES; i++) begin
            s_res[i*LANE_WIDTH +: LANE_WIDTH] = lane_s(opCode, inA[i*LANE_WIDTH +: LANE_WIDTH],
                                                       inB[i*LANE_WIDTH +: LANE_WIDTH]);
            prod[i*LANE_WIDTH +: LANE_WIDTH]  = inA[i*LANE_WIDTH +: LANE_WIDTH]
                                              * inB[i*LANE_WIDTH +: LANE_WIDTH];
            amt_in[i*SHW +: SHW]              = inB[i*LANE_WIDTH +: SHW];
            m_res[i*LANE_WIDTH +: LANE_WIDTH] = lane_m(s1_op_q, s1_dat_q[i*LANE_WIDTH +: LANE_WIDTH],
                                                       s1_amt_q[i*SHW +: SHW]);
            s_zero[i] = ~|s_res[i*LANE_WIDTH +: LANE_WIDTH];
            m_zero[i] = ~|m_res[i*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    always_comb begin
        is_m    = 1'b0;
        illegal = 1'b0;
        mop_in  = M_MUL;
        case (opCode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: ;
            OP_MUL: is_m = 1'b1;
            OP_SHL: begin is_m = 1'b1; mop_in = M_SHL; end
            OP_ROL: begin is_m = 1'b1; mop_in = M_ROL; end
            default: illegal = 1'b1;
        endcase
    end

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        s1_op_d  = s1_op_q;
        s1_dat_d = s1_dat_q;
        s1_amt_d = s1_amt_q;
        dout_d   = dout_q;
        zero_d   = zero_q;
        err_d    = err_q;
        vld_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_m) begin
                        s1_op_d  = mop_in;
                        s1_dat_d = (mop_in == M_MUL) ? prod : inA;
                        s1_amt_d = amt_in;
                        state_d  = EXEC;
                    end else begin
                        dout_d = illegal ? '0 : s_res;
                        zero_d = illegal ? '0 : s_zero;
                        err_d  = illegal;
                        vld_d  = 1'b1;
                    end
                end
            end
            EXEC: begin
                dout_d  = m_res;
                zero_d  = m_zero;
                err_d   = 1'b0;
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(negedge clk_fake or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s1_op_q  <= M_MUL;
            s1_dat_q <= '0;
            s1_amt_q <= '0;
            dout_q   <= '0;
            zero_q   <= '0;
            err_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_op_q  <= s1_op_d;
            s1_dat_q <= s1_dat_d;
            s1_amt_q <= s1_amt_d;
            dout_q   <= dout_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            vld_q    <= vld_d;
        end
    end

    assign out_valid = vld_q;
    assign dataOut   = dout_q;
    assign zeroOut   = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Scoreboard bench for simd_alu_pipe: expected results queued at issue, popped when out_valid is seen.
module tb_simd_alu_pipe;

    localparam int LW    = 32;
    localparam int LANES = 4;
    localparam int W     = LW * LANES;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    typedef struct packed {
        logic [W-1:0]     d;
        logic [LANES-1:0] z;
        logic             e;
    } res_t;

    logic             clk_fake = 1'b1;
    logic             rst_n    = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       opCode   = 4'd0;
    logic [W-1:0]     inA      = '0;
    logic [W-1:0]     inB      = '0;
    logic             out_valid;
    logic [W-1:0]     dataOut;
    logic [LANES-1:0] zeroOut;
    logic             err;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    simd_alu_pipe #(.LANE_WIDTH(LW), .LANES(LANES)) dut (
        .clk_fake (clk_fake),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opCode   (opCode),
        .inA      (inA),
        .inB      (inB),
        .out_valid(out_valid),
        .dataOut  (dataOut),
        .zeroOut  (zeroOut),
        .err      (err)
    );

    always #5 clk_fake = ~clk_fake;

    function automatic logic [W-1:0] pack(input logic [LW-1:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t             r;
        logic [LW-1:0]    x, y, q;
        logic [2*LW-1:0]  dd;
        longint           s;
        int               amt;
        r = '0;
        if (!(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8})) begin
            r.e = 1'b1;
            return r;
        end
        for (int i = 0; i < LANES; i++) begin
            x   = a[i*LW +: LW];
            y   = b[i*LW +: LW];
            amt = int'(y[4:0]);
            s   = 0;
            case (op)
                4'd0, 4'd1: begin
`ifdef SPU_ALU_SAT_EN
                    if (op == 4'd0) s = longint'($signed(x)) + longint'($signed(y));
                    else            s = longint'($signed(x)) - longint'($signed(y));
                    if (s > SMAX) s = SMAX;
                    if (s < SMIN) s = SMIN;
                    q = s[LW-1:0];
`else
                    q = (op == 4'd0) ? x + y : x - y;
`endif
                end
                4'd2:    q = x * y;
                4'd3:    q = x & y;
                4'd4:    q = x | y;
                4'd7:    q = x << amt;
                default: begin
                    dd = {x, x} << amt;
                    q  = dd[2*LW-1:LW];
                end
            endcase
            r.d[i*LW +: LW] = q;
            r.z[i]          = (q == '0);
        end
        return r;
    endfunction

    // Issues one op, then waits (bounded) for out_valid; observed values are returned, not judged.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output res_t obs, output int lat);
        @(posedge clk_fake);
        in_valid = 1'b1;
        opCode   = op;
        inA      = a;
        inB      = b;
        exp_q.push_back(model(op, a, b));
        @(negedge clk_fake);
        @(posedge clk_fake);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(posedge clk_fake);
            lat++;
        end
        obs = {dataOut, zeroOut, err};
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, dataOut, zeroOut, err} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got vld=%b d=%h z=%b e=%b want all zero", out_valid, dataOut, zeroOut, err);
        end
        @(posedge clk_fake);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        res_t obs, exp;
        int   lat;
        run_op(4'd0, pack(1, 2, 3, 4), pack(4, 3, 2, 32'hFFFFFFFF), obs, lat);
        exp = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL add_result: got %h want %h", obs, exp); end
        n_cmp++;
        if (lat !== 0) begin n_bad++; $display("FAIL add_latency: got %0d want 0", lat); end
        @(posedge clk_fake);
        n_cmp++;
        if ({out_valid, dataOut} !== {1'b0, exp.d}) begin
            n_bad++;
            $display("FAIL add_hold: got vld=%b d=%h want vld=0 d=%h", out_valid, dataOut, exp.d);
        end
    endtask

    task automatic test_reset_mid();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, dataOut, zeroOut, err} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got d=%h z=%b e=%b want zero", dataOut, zeroOut, err);
        end
        @(posedge clk_fake);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_sub();
        res_t obs, exp;
        int   lat;
        run_op(4'd1, pack(32'hDEADBEEF, 5, 0, 32'h80000000), pack(32'hDEADBEEF, 5, 0, 32'h80000000), obs, lat);
        exp = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL sub_equal: got %h want %h", obs, exp); end
        run_op(4'd1, pack(0, 32'h80000000, 10, 32'h7FFFFFFF), pack(1, 1, 3, 32'hFFFFFFFF), obs, lat);
        exp = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL sub_borrow: got %h want %h", obs, exp); end
        n_cmp++;
        if (lat !== 0) begin n_bad++; $display("FAIL sub_latency: got %0d want 0", lat); end
    endtask

    task automatic test_mul_b2b();
        res_t         obs, exp;
        logic [W-1:0] a, b;
        a = pack(32'h10000, 7, 9, 32'hFFFFFFFF);
        b = pack(32'h10000, 6, 0, 2);
        @(posedge clk_fake);
        in_valid = 1'b1; opCode = 4'd2; inA = a; inB = b;
        exp_q.push_back(model(4'd2, a, b));
        @(negedge clk_fake);
        @(posedge clk_fake);
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL mul_busy: got rdy=%b vld=%b want rdy=0 vld=0", in_ready, out_valid);
        end
        a = pack(32'hFF00FF00, 32'h0F0F0F0F, 0, 32'hFFFFFFFF);
        b = pack(32'h0FF00FF0, 32'hF0F0F0F0, 5, 32'h12345678);
        opCode = 4'd3; inA = a; inB = b;
        exp_q.push_back(model(4'd3, a, b));
        @(negedge clk_fake);
        @(posedge clk_fake);
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b11) begin
            n_bad++;
            $display("FAIL mul_done: got rdy=%b vld=%b want rdy=1 vld=1", in_ready, out_valid);
        end
        exp = exp_q.pop_front();
        obs = {dataOut, zeroOut, err};
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL mul_result: got %h want %h", obs, exp); end
        @(negedge clk_fake);
        @(posedge clk_fake);
        in_valid = 1'b0;
        exp = exp_q.pop_front();
        obs = {dataOut, zeroOut, err};
        n_cmp++;
        if ({out_valid, obs} !== {1'b1, exp}) begin
            n_bad++;
            $display("FAIL and_after_mul: got vld=%b %h want vld=1 %h", out_valid, obs, exp);
        end
        @(posedge clk_fake);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_strobe_end: got %b want 0", out_valid); end
    endtask

    task automatic test_shift_rot();
        res_t         obs, exp;
        int           lat;
        logic [W-1:0] a, b;
        a = pack(32'h80000001, 32'h12345678, 32'hF0F0F0F1, 32'hDEADBEEF);
        b = pack(33, 0, 31, 4);
        run_op(4'd8, a, b, obs, lat);
        exp = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL rotate: got %h want %h", obs, exp); end
        n_cmp++;
        if (lat !== 1) begin n_bad++; $display("FAIL rotate_latency: got %0d want 1", lat); end
        run_op(4'd7, a, b, obs, lat);
        exp = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL shift: got %h want %h", obs, exp); end
        n_cmp++;
        if (obs.d[LW-1:0] !== 32'h00000002) begin
            n_bad++;
            $display("FAIL shift_lane0: got %h want 00000002", obs.d[LW-1:0]);
        end
    endtask

    task automatic test_illegal();
        res_t obs, exp;
        int   lat;
        run_op(4'd5, pack(1, 2, 3, 4), pack(5, 6, 7, 8), obs, lat);
        exp = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL illegal_0101: got %h want %h", obs, exp); end
        n_cmp++;
        if (lat !== 0) begin n_bad++; $display("FAIL illegal_latency: got %0d want 0", lat); end
        run_op(4'd15, pack(9, 9, 9, 9), pack(1, 1, 1, 1), obs, lat);
        exp = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL illegal_1111: got %h want %h", obs, exp); end
        run_op(4'd3, pack(32'hFFFF0000, 3, 0, 8), pack(32'h00FFFF00, 1, 7, 8), obs, lat);
        exp = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL and_clears_err: got %h want %h", obs, exp); end
    endtask

    task automatic test_reset_exec();
        int seen;
        @(posedge clk_fake);
        in_valid = 1'b1; opCode = 4'd2; inA = pack(3, 3, 3, 3); inB = pack(5, 5, 5, 5);
        @(negedge clk_fake);
        @(posedge clk_fake);
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL exec_entered: got rdy=%b want 0", in_ready); end
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_fake);
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin n_bad++; $display("FAIL exec_reset_no_vld: got %0d strobes want 0", seen); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL exec_reset_idle: got rdy=%b want 1", in_ready); end
    endtask

    task automatic test_sat_add();
        res_t obs, exp;
        int   lat;
        run_op(4'd0, pack(32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 100),
                     pack(1, 32'hFFFFFFFF, 1, 32'hFFFFFF9C), obs, lat);
        exp = exp_q.pop_front();
        n_cmp++;
        if (obs !== exp) begin n_bad++; $display("FAIL add_edge: got %h want %h", obs, exp); end
`ifdef SPU_ALU_SAT_EN
        n_cmp++;
        if (obs.d[LW-1:0] !== 32'h7FFFFFFF) begin
            n_bad++;
            $display("FAIL sat_clamp: got %h want 7fffffff", obs.d[LW-1:0]);
        end
`else
        n_cmp++;
        if (obs.d[LW-1:0] !== 32'h80000000) begin
            n_bad++;
            $display("FAIL wrap_add: got %h want 80000000", obs.d[LW-1:0]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_reset_mid();
        test_sub();
        test_mul_b2b();
        test_shift_rot();
        test_illegal();
        test_reset_exec();
        test_sat_add();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
